binary_decoder_stream: RTL and testbench
========================================

# binary_decoder_stream

Streaming 4-to-16 binary-to-one-hot decoder with a valid/ready handshake on both sides and a small input FIFO. It accepts binary codes with a per-code enable and emits one-hot words (all-zero when disabled). It sits downstream of the priority/binary encoders and regenerates select lines for the consumer side of the datapath. A saturating counter reports how many words have been delivered.

## Interface
- IN_W, 4: binary code width.
- OUT_W, 1<<IN_W (16): one-hot output width; must equal 2**IN_W.
- DEPTH, 2: FIFO entries; power of two, ≥2.
- CNT_W, 16: delivered-word counter width.

- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  sampled with each accepted code; 0 → that word decodes to all-zero.
- in_valid  input  1  producer has a code on binary_in.
- in_ready  output  1  block can accept; transfer when in_valid && in_ready.
- binary_in  input  IN_W  code to decode.
- out_valid  output  1  decoder_out holds a valid word.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
- decoder_out  output  OUT_W  one-hot word, bit[binary_in] set, or all-zero.
- delivered_cnt  output  CNT_W  saturating count of output transfers.

## Operation
- FIFO stores {enable, binary_in} per entry (IN_W+1 bits); decode happens at the FIFO head.
- decoder_out = head.enable ? (1 << head.code) : '0; driven '0 whenever out_valid=0.
- in_ready = !full; registered-path only, no combinational dependence on out_ready.
- out_valid = !empty.
- Push when in_valid && in_ready; pop when out_valid && out_ready; both in one cycle allowed (occupancy unchanged).
- Full: in_ready=0; in_valid ignored, binary_in/enable need not be held by the block (producer must hold per handshake).
- Empty: out_valid=0, decoder_out='0; out_ready ignored.
- Pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
- delivered_cnt increments on every pop (disabled/all-zero words included); saturates at all-ones, never wraps.
- Producer rule: once in_valid is high it stays high with stable data until accepted; block does not check.
- Consumer rule: out_valid/decoder_out stay stable until popped.

## Timing
- Reset (async assert, sync deassert by system): FIFO empty, pointers 0, in_ready=1 after reset release, out_valid=0, decoder_out='0, delivered_cnt=0.
- Reset mid-operation: all stored entries discarded immediately; no partial word emitted.
- Latency: code accepted at edge N → out_valid=1 with decoded word in cycle after edge N (1 cycle).
- Throughput: 1 word/cycle sustained with out_ready held high.
- in_ready falls the cycle after the push that fills the FIFO; rises the cycle after the first pop from full.
- Push into empty FIFO with out_ready=1: word appears next cycle, popped at the following edge.

## Structure
- Package decoder_pkg: default IN_W, derived OUT_W, entry typedef (struct packed {logic en; logic [IN_W-1:0] code;}), function onehot_decode(en, code).
- Sub-module decoder_fifo: parameterised DEPTH/width sync FIFO with full/empty; top adds decode and counter.

## Test plan
- Reset then push code 4'h1, enable=1, out_ready=1 → next cycle out_valid=1, decoder_out=16'h0002; delivered_cnt=1 after pop.
- Push 4'hF with enable=0 → decoder_out=16'h0000 with out_valid=1; delivered_cnt still increments.
- Hold out_ready=0, push 4'h3, 4'h7 → in_ready=0 after second push; third push ignored; release out_ready → 16'h0008 then 16'h0080, in order.
- Back-to-back codes 0..15, out_ready=1 → sixteen consecutive one-hot words 16'h0001..16'h8000, one per cycle, no bubbles.
- Full FIFO, pulse rst_n low mid-cycle → out_valid, decoder_out, delivered_cnt go 0 asynchronously; in_ready=1 after release.
- Force delivered_cnt near max (CNT_W=4 build), deliver 20 words → counter holds at 4'hF.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared widths, FIFO entry layout and the one-hot decode helper for the select-line regenerator.
`timescale 1ns/1ps
package decoder_pkg;

  localparam int unsigned DEFAULT_IN_W  = 4;
  localparam int unsigned DEFAULT_OUT_W = 1 << DEFAULT_IN_W;

  typedef struct packed {
    logic                    en;
    logic [DEFAULT_IN_W-1:0] code;
  } entry_t;

  // One-hot word with bit[code] set, or all-zero when the code was disabled.
  function automatic logic [DEFAULT_OUT_W-1:0] onehot_decode(input logic en,
                                                             input logic [DEFAULT_IN_W-1:0] code);
    onehot_decode = '0;
    if (en) onehot_decode[code] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_fifo.sv
// Small synchronous FIFO holding {enable, code} entries ahead of the decoder.
`timescale 1ns/1ps
module decoder_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: nothing reads it until count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (do_pop)  rd_ptr <= AW'(rd_ptr + 1'b1);
      case ({do_push, do_pop})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/binary_decoder_stream.sv
// Streaming binary-to-one-hot decoder: FIFO-buffered codes, decode at the head, saturating delivery count.
`timescale 1ns/1ps
module binary_decoder_stream
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W  = DEFAULT_IN_W,
  parameter int unsigned OUT_W = 1 << IN_W,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  binary_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] decoder_out,
  output logic [CNT_W-1:0] delivered_cnt
);

  localparam int unsigned EW = IN_W + 1;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [OUT_W-1:0] decoded;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  decoder_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({enable, binary_in}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Shared helper for the standard width; generic shift for other builds.
  generate
    if (IN_W == DEFAULT_IN_W) begin : g_pkg_decode
      entry_t head_entry;
      assign head_entry = entry_t'(head);
      assign decoded    = onehot_decode(head_entry.en, head_entry.code);
    end else begin : g_gen_decode
      assign decoded = head[IN_W] ? (OUT_W'(1) << head[IN_W-1:0]) : '0;
    end
  endgenerate

  assign decoder_out = out_valid ? decoded : '0;

  // Counts every delivered word, including disabled all-zero ones; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delivered_cnt <= '0;
    end else if (pop && (delivered_cnt != '1)) begin
      delivered_cnt <= CNT_W'(delivered_cnt + 1'b1);
    end
  end

endmodule

// File: tb/tb_binary_decoder_stream.sv
// Scoreboard bench: expected one-hot words are queued on accept and compared on delivery.
`timescale 1ns/1ps
module tb_binary_decoder_stream;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        enable    = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  binary_in = 4'h0;

  logic        in_ready,  out_valid;
  logic [15:0] decoder_out;
  logic [15:0] cnt;
  logic        in_ready4, out_valid4;
  logic [15:0] dout4;
  logic [3:0]  cnt4;

  int          n_vec     = 0;
  int          n_err     = 0;
  int          model_cnt = 0;
  int          pop_total = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  binary_decoder_stream #(.IN_W(4), .OUT_W(16), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .binary_in(binary_in), .out_valid(out_valid), .out_ready(out_ready),
    .decoder_out(decoder_out), .delivered_cnt(cnt)
  );

  binary_decoder_stream #(.IN_W(4), .OUT_W(16), .DEPTH(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready4),
    .binary_in(binary_in), .out_valid(out_valid4), .out_ready(out_ready),
    .decoder_out(dout4), .delivered_cnt(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Observe the handshake mid-cycle; it commits at the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [15:0] e;
      check("cnt16", 32'(cnt), 32'(model_cnt));
      check("cnt4_sat", 32'(cnt4), (model_cnt > 15) ? 32'd15 : 32'(model_cnt));
      if (!out_valid) check("idle_zero", 32'(decoder_out), 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("word", 32'(decoder_out), 32'(e));
        end
        model_cnt++;
        pop_total++;
      end
      if (in_valid && in_ready) begin
        e = enable ? (16'h0001 << binary_in) : 16'h0000;
        sb.push_back(e);
      end
    end
  end

  // Called at posedge+1; holds the code until accepted and returns cycles taken.
  task automatic send(input logic [3:0] code, input logic en, output int cycles);
    bit acc;
    acc    = 1'b0;
    cycles = 0;
    in_valid  = 1'b1;
    binary_in = code;
    enable    = en;
    while (!acc && cycles < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    int c;
    int p0;
    int budget;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),    32'd1);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_dout",      32'(decoder_out), 32'd0);
    check("rst_cnt",       32'(cnt),         32'd0);

    // Single enabled code, one-cycle latency
    out_ready = 1'b1;
    send(4'h1, 1'b1, c);
    check("lat_valid", 32'(out_valid),   32'd1);
    check("lat_word",  32'(decoder_out), 32'h0002);
    @(posedge clk); #1;
    check("cnt_after1", 32'(cnt), 32'd1);

    // Disabled code decodes to zero but still counts
    send(4'hF, 1'b0, c);
    check("dis_valid", 32'(out_valid),   32'd1);
    check("dis_word",  32'(decoder_out), 32'h0000);
    @(posedge clk); #1;
    check("cnt_after2", 32'(cnt), 32'd2);

    // Backpressure: fill, refuse a third, drain in order
    out_ready = 1'b0;
    send(4'h3, 1'b1, c);
    send(4'h7, 1'b1, c);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid  = 1'b1;
    binary_in = 4'h9;
    enable    = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("full_hold", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("drain_first", 32'(decoder_out), 32'h0008);
    @(posedge clk); #1;
    check("drain_second", 32'(decoder_out), 32'h0080);
    check("ready_reopen", 32'(in_ready),    32'd1);
    @(posedge clk); #1;
    check("drained", 32'(out_valid), 32'd0);

    // Back-to-back 0..15 at full rate
    p0 = pop_total;
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 1'b1, c);
      check("b2b_accept_cycles", 32'(c), 32'd1);
    end
    @(posedge clk); #1;
    check("b2b_pops", 32'(pop_total - p0), 32'd16);
    check("b2b_empty", 32'(out_valid), 32'd0);
    check("cnt16_20", 32'(cnt), 32'd20);
    check("cnt4_held", 32'(cnt4), 32'hF);

    // Asynchronous reset while full
    out_ready = 1'b0;
    send(4'hA, 1'b1, c);
    send(4'hB, 1'b1, c);
    check("pre_rst_full",  32'(in_ready),  32'd0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid),   32'd0);
    check("arst_dout",  32'(decoder_out), 32'd0);
    check("arst_cnt",   32'(cnt),         32'd0);
    check("arst_cnt4",  32'(cnt4),        32'd0);
    sb.delete();
    model_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(in_ready),  32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Traffic resumes after reset
    out_ready = 1'b1;
    send(4'h5, 1'b1, c);
    check("post_rst_word", 32'(decoder_out), 32'h0020);
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    check("final_cnt", 32'(cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
